// File: rtl/sysio_pkg.sv
// Shared definitions for the sysio peripheral fabric: default bus widths and
// the lock-state encoding used by the two-master arbiter.
package sysio_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_e;

  // One-hot view of the lock holder, 2'b00 when nobody holds the lock.
  function automatic logic [1:0] lock_onehot(input lock_state_e st);
    logic [1:0] oh;
    case (st)
      LOCK0:   oh = 2'b01;
      LOCK1:   oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. Masked requesters never win; on a tie the
// requester that did not win last time gets the grant.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic [1:0] mask_i,
  output logic [1:0] grant_o
);

  logic [1:0] eff_req_s;

  // Combinational pick among the unmasked requesters.
  always_comb begin
    eff_req_s = req_i & ~mask_i;
    grant_o   = 2'b00;
    case (eff_req_s)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/sysio_axi_arb.sv
// Two-master AXI4-Lite arbiter in front of the sysio slave port: independent
// round-robin on W and AR, read-response routing, and a per-master lock.
module sysio_axi_arb
  import sysio_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic [1:0]        lock_owner
);

  lock_state_e lock_q, lock_d;
  logic wr_last_q, wr_last_d, rd_last_q, rd_last_d;
  logic rd_owner_q, rd_owner_d, rd_pend_q, rd_pend_d;
  logic wr_hold_q, wr_hold_d, wr_hold_idx_q, wr_hold_idx_d;
  logic rd_hold_q, rd_hold_d, rd_hold_idx_q, rd_hold_idx_d;

  logic [1:0] mask_s, wr_req_s, wr_gnt_s, rd_req_s, rd_gnt_s;
  logic       wr_ptr_s, rd_ptr_s, wr_idx_s, rd_idx_s;
  logic       wr_hs_s, ar_hs_s, r_hs_s, ar_allow_s, m0_hs_s, m1_hs_s;

  // A granted-but-stalled master keeps priority until its handshake.
  assign wr_ptr_s = wr_hold_q ? ~wr_hold_idx_q : wr_last_q;
  assign rd_ptr_s = rd_hold_q ? ~rd_hold_idx_q : rd_last_q;
  assign wr_req_s = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  assign rd_req_s = {m1_arvalid, m0_arvalid};

  rr_arb2 u_wr_arb (
    .req_i   (wr_req_s),
    .last_i  (wr_ptr_s),
    .mask_i  (mask_s),
    .grant_o (wr_gnt_s)
  );

  rr_arb2 u_rd_arb (
    .req_i   (rd_req_s),
    .last_i  (rd_ptr_s),
    .mask_i  (mask_s),
    .grant_o (rd_gnt_s)
  );

  assign wr_idx_s   = wr_gnt_s[1];
  assign s_awvalid  = |wr_gnt_s;
  assign s_wvalid   = |wr_gnt_s;
  assign s_awaddr   = wr_idx_s ? m1_awaddr : m0_awaddr;
  assign s_wdata    = wr_idx_s ? m1_wdata : m0_wdata;
  assign s_wstrb    = wr_idx_s ? m1_wstrb : m0_wstrb;
  assign m0_awready = wr_gnt_s[0] & s_awready;
  assign m0_wready  = wr_gnt_s[0] & s_wready;
  assign m1_awready = wr_gnt_s[1] & s_awready;
  assign m1_wready  = wr_gnt_s[1] & s_wready;
  assign wr_hs_s    = (|wr_gnt_s) & s_awready & s_wready;

  // Only one read may be outstanding, but a new AR may ride on the R handshake.
  assign r_hs_s     = s_rvalid & s_rready;
  assign ar_allow_s = ~rd_pend_q | r_hs_s;
  assign rd_idx_s   = rd_gnt_s[1];
  assign s_arvalid  = (|rd_gnt_s) & ar_allow_s;
  assign s_araddr   = rd_idx_s ? m1_araddr : m0_araddr;
  assign m0_arready = rd_gnt_s[0] & ar_allow_s & s_arready;
  assign m1_arready = rd_gnt_s[1] & ar_allow_s & s_arready;
  assign ar_hs_s    = s_arvalid & s_arready;

  assign s_rready  = rd_owner_q ? m1_rready : m0_rready;
  assign m0_rvalid = s_rvalid & ~rd_owner_q;
  assign m1_rvalid = s_rvalid & rd_owner_q;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;

  assign m0_hs_s = (wr_hs_s & ~wr_idx_s) | (ar_hs_s & ~rd_idx_s);
  assign m1_hs_s = (wr_hs_s & wr_idx_s) | (ar_hs_s & rd_idx_s);

  // Lock decode: the non-holder is masked on both channels.
  always_comb begin
    lock_owner = lock_onehot(lock_q);
    mask_s     = 2'b00;
    case (lock_q)
      LOCK0:   mask_s = 2'b10;
      LOCK1:   mask_s = 2'b01;
      default: mask_s = 2'b00;
    endcase
  end

  // Next-state for pointers, read tracking, grant hold and lock FSM.
  always_comb begin
    wr_last_d     = wr_last_q;
    rd_last_d     = rd_last_q;
    rd_owner_d    = rd_owner_q;
    rd_pend_d     = rd_pend_q;
    lock_d        = lock_q;
    wr_hold_d     = (|wr_gnt_s) & ~wr_hs_s;
    wr_hold_idx_d = wr_idx_s;
    rd_hold_d     = (|rd_gnt_s) & ~ar_hs_s;
    rd_hold_idx_d = rd_idx_s;

    if (wr_hs_s) begin
      wr_last_d = wr_idx_s;
    end else begin
      wr_last_d = wr_last_q;
    end

    if (ar_hs_s) begin
      rd_last_d  = rd_idx_s;
      rd_owner_d = rd_idx_s;
      rd_pend_d  = 1'b1;
    end else if (r_hs_s) begin
      rd_pend_d  = 1'b0;
    end else begin
      rd_pend_d  = rd_pend_q;
    end

    case (lock_q)
      UNLOCKED: begin
        if (m0_hs_s & m0_lock) begin
          lock_d = LOCK0;
        end else if (m1_hs_s & m1_lock) begin
          lock_d = LOCK1;
        end else begin
          lock_d = UNLOCKED;
        end
      end
      LOCK0: begin
        if (~m0_lock & (~(s_rvalid & ~rd_owner_q) | r_hs_s)) begin
          lock_d = UNLOCKED;
        end else begin
          lock_d = LOCK0;
        end
      end
      LOCK1: begin
        if (~m1_lock & (~(s_rvalid & rd_owner_q) | r_hs_s)) begin
          lock_d = UNLOCKED;
        end else begin
          lock_d = LOCK1;
        end
      end
      default: lock_d = UNLOCKED;
    endcase
  end

  // State registers; pointers start at 1 so M0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_q     <= 1'b1;
      rd_last_q     <= 1'b1;
      rd_owner_q    <= 1'b0;
      rd_pend_q     <= 1'b0;
      lock_q        <= UNLOCKED;
      wr_hold_q     <= 1'b0;
      wr_hold_idx_q <= 1'b0;
      rd_hold_q     <= 1'b0;
      rd_hold_idx_q <= 1'b0;
    end else begin
      wr_last_q     <= wr_last_d;
      rd_last_q     <= rd_last_d;
      rd_owner_q    <= rd_owner_d;
      rd_pend_q     <= rd_pend_d;
      lock_q        <= lock_d;
      wr_hold_q     <= wr_hold_d;
      wr_hold_idx_q <= wr_hold_idx_d;
      rd_hold_q     <= rd_hold_d;
      rd_hold_idx_q <= rd_hold_idx_d;
    end
  end

endmodule

// File: tb/tb_sysio_axi_arb.sv
// Scoreboard bench for sysio_axi_arb: directed stimulus pushes expected slave
// writes and master read responses; a negedge monitor pops and compares.
module tb_sysio_axi_arb;

  logic        clk, rst_n;
  logic [31:0] m0_awaddr, m1_awaddr, m0_wdata, m1_wdata, m0_araddr, m1_araddr;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_awvalid, m0_wvalid, m0_arvalid, m0_rready, m0_lock;
  logic        m1_awvalid, m1_wvalid, m1_arvalid, m1_rready, m1_lock;
  logic        m0_awready, m0_wready, m0_arready, m0_rvalid;
  logic        m1_awready, m1_wready, m1_arready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready;
  logic        s_rvalid, s_rready;
  logic [1:0]  lock_owner;

  int checks = 0;
  int errors = 0;

  typedef struct { logic mst; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wexp_t;
  typedef struct { logic mst; logic [31:0] data; } rexp_t;
  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t we;
  rexp_t re;

  sysio_axi_arb #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_lock(m0_lock),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_lock(m1_lock),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .lock_owner(lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sysio slave model: combinational readies, read data one cycle after AR.
  assign s_awready = s_awvalid & s_wvalid;
  assign s_wready  = s_awvalid & s_wvalid;
  assign s_arready = s_arvalid;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    case (a)
      32'h0000_4004: return 32'h0000_1234;
      32'h0000_4000: return 32'h00C0_FFEE;
      default:       return 32'hD000_0000 | a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
    end else if (s_arvalid && s_arready) begin
      s_rvalid <= 1'b1;
      s_rdata  <= slv_data(s_araddr);
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Monitor: every slave write and every master R handshake is scored.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_awvalid && s_awready && s_wvalid && s_wready) begin
        if (wq.size() == 0) begin
          chk("w_unexpected", 32'(wq.size()), 32'd1);
        end else begin
          we = wq.pop_front();
          chk_b("w_master", m1_awready, we.mst);
          chk("w_addr", s_awaddr, we.addr);
          chk("w_data", s_wdata, we.data);
          chk("w_strb", {28'd0, s_wstrb}, {28'd0, we.strb});
        end
      end
      if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 32'(rq.size()), 32'd1);
        end else begin
          re = rq.pop_front();
          chk_b("r_master", m1_rvalid, re.mst);
          chk("r_data", re.mst ? m1_rdata : m0_rdata, re.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_awaddr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_araddr = 32'h0;
    m0_awvalid = 1'b0; m0_wvalid = 1'b0; m0_arvalid = 1'b0; m0_rready = 1'b0; m0_lock = 1'b0;
    m1_awaddr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0; m1_araddr = 32'h0;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; m1_arvalid = 1'b0; m1_rready = 1'b0; m1_lock = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk("rst_lock_owner", {30'd0, lock_owner}, 32'd0);
    chk_b("rst_s_awvalid", s_awvalid, 1'b0);
    chk_b("rst_s_arvalid", s_arvalid, 1'b0);
    chk_b("rst_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Both masters write every cycle: M0, M1, M0, M1.
    for (int c = 0; c < 4; c++) begin
      if ((c % 2) == 0) wq.push_back('{1'b0, 32'h4000, 32'hA0, 4'h1});
      else              wq.push_back('{1'b1, 32'h4010, 32'hB1, 4'h3});
    end
    m0_awaddr = 32'h4000; m0_wdata = 32'hA0; m0_wstrb = 4'h1; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    m1_awaddr = 32'h4010; m1_wdata = 32'hB1; m1_wstrb = 4'h3; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk_b("t1_m0_wready", m0_wready, (c % 2) == 0);
      chk_b("t1_m1_wready", m1_wready, (c % 2) == 1);
      tick();
    end
    idle();

    // M1 reads 0x4004 alone.
    rq.push_back('{1'b1, 32'h1234});
    m1_arvalid = 1'b1; m1_araddr = 32'h4004; m1_rready = 1'b1;
    #2 chk_b("t2_m1_arready", m1_arready, 1'b1);
    tick();
    m1_arvalid = 1'b0;
    #2;
    chk_b("t2_m1_rvalid", m1_rvalid, 1'b1);
    chk_b("t2_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    idle();

    // M0 stalls its R for 3 cycles; M1's AR waits and rides on the R handshake.
    rq.push_back('{1'b0, 32'h00C0_FFEE});
    rq.push_back('{1'b1, 32'hD000_4008});
    m0_arvalid = 1'b1; m0_araddr = 32'h4000;
    tick();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b1; m1_araddr = 32'h4008; m1_rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk_b("t3_m1_arready_stall", m1_arready, 1'b0);
      chk_b("t3_m0_rvalid_hold", m0_rvalid, 1'b1);
      tick();
    end
    m0_rready = 1'b1;
    #2 chk_b("t3_m1_arready_same", m1_arready, 1'b1);
    tick();
    m1_arvalid = 1'b0; m0_rready = 1'b0;
    #2;
    chk_b("t3_m1_rvalid", m1_rvalid, 1'b1);
    chk_b("t3_m0_rvalid", m0_rvalid, 1'b0);
    tick();
    idle();

    // M1 locks with a read, then writes; M0's concurrent write waits for unlock.
    rq.push_back('{1'b1, 32'h00C0_FFEE});
    wq.push_back('{1'b1, 32'h4000, 32'h55, 4'hF});
    wq.push_back('{1'b0, 32'h4020, 32'hA0, 4'hF});
    m1_lock = 1'b1; m1_arvalid = 1'b1; m1_araddr = 32'h4000; m1_rready = 1'b1;
    #2 chk("t4_owner_pre", {30'd0, lock_owner}, 32'd0);
    tick();
    m1_arvalid = 1'b0;
    m1_awaddr = 32'h4000; m1_wdata = 32'h55; m1_wstrb = 4'hF; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    m0_awaddr = 32'h4020; m0_wdata = 32'hA0; m0_wstrb = 4'hF; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    #2;
    chk("t4_owner_b", {30'd0, lock_owner}, 32'd2);
    chk_b("t4_m0_awready_b", m0_awready, 1'b0);
    chk_b("t4_m1_awready_b", m1_awready, 1'b1);
    tick();
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    #2;
    chk("t4_owner_c", {30'd0, lock_owner}, 32'd2);
    chk_b("t4_m0_wready_c", m0_wready, 1'b0);
    tick();
    m1_lock = 1'b0;
    #2;
    chk("t4_owner_d", {30'd0, lock_owner}, 32'd2);
    chk_b("t4_m0_awready_d", m0_awready, 1'b0);
    tick();
    #2;
    chk("t4_owner_e", {30'd0, lock_owner}, 32'd0);
    chk_b("t4_m0_awready_e", m0_awready, 1'b1);
    tick();
    idle();

    // M0 write and M1 read handshake in the same cycle.
    wq.push_back('{1'b0, 32'h4030, 32'h77, 4'hF});
    rq.push_back('{1'b1, 32'h1234});
    m0_awaddr = 32'h4030; m0_wdata = 32'h77; m0_wstrb = 4'hF; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h4004; m1_rready = 1'b1;
    #2;
    chk_b("t5_m0_awready", m0_awready, 1'b1);
    chk_b("t5_m1_arready", m1_arready, 1'b1);
    tick();
    m0_awvalid = 1'b0; m0_wvalid = 1'b0; m1_arvalid = 1'b0;
    tick();
    idle();

    // Reset with a read pending and M0 holding the lock.
    m0_lock = 1'b1; m0_arvalid = 1'b1; m0_araddr = 32'h4000;
    tick();
    m0_arvalid = 1'b0;
    #2;
    chk("t6_owner_locked", {30'd0, lock_owner}, 32'd1);
    chk_b("t6_m0_rvalid_pend", m0_rvalid, 1'b1);
    rst_n = 1'b0;
    idle();
    #1;
    chk("t6_owner_rst", {30'd0, lock_owner}, 32'd0);
    chk_b("t6_m0_rvalid_rst", m0_rvalid, 1'b0);
    chk_b("t6_s_arvalid_rst", s_arvalid, 1'b0);
    chk_b("t6_m0_awready_rst", m0_awready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    wq.push_back('{1'b0, 32'h4040, 32'h11, 4'hF});
    rq.push_back('{1'b0, 32'h1234});
    m0_awaddr = 32'h4040; m0_wdata = 32'h11; m0_wstrb = 4'hF; m0_awvalid = 1'b1; m0_wvalid = 1'b1;
    m1_awaddr = 32'h4050; m1_wdata = 32'h22; m1_wstrb = 4'hF; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 32'h4004; m0_rready = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h4008;
    #2;
    chk_b("t6_m0_awready", m0_awready, 1'b1);
    chk_b("t6_m1_awready", m1_awready, 1'b0);
    chk_b("t6_m0_arready", m0_arready, 1'b1);
    chk_b("t6_m1_arready", m1_arready, 1'b0);
    tick();
    idle();
    m0_rready = 1'b1;
    tick();
    idle();

    for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) tick();
    chk("wq_drain", 32'(wq.size()), 32'd0);
    chk("rq_drain", 32'(rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
